imm_ins_encoder: RTL and testbench

Inverse of the decode-stage immediate extraction. Accepts high-level commands (load 32-bit constant, store word, load word, CSR write-immediate) and emits the encoded RV32I instruction words, splitting immediates into the I/S/U field layouts. Drives an instruction-injection stream for the debug/boot path into the fetch/decode pipeline. Valid/ready on both sides; multi-word sequences via a small FSM.

---
 rtl/imm_ins_encoder_pkg.sv | 60 ++++++
 rtl/imm_ins_encoder.sv | 139 +++++++++++++
 tb/tb_imm_ins_encoder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/imm_ins_encoder_pkg.sv
// Shared RV32I encoding constants, command/state enums and field packers
// used by the instruction-injection encoder and future assemblers.
package imm_ins_encoder_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADDI   = 3'b000;
    localparam logic [2:0] F3_LW     = 3'b010;
    localparam logic [2:0] F3_SW     = 3'b010;
    localparam logic [2:0] F3_CSRRWI = 3'b101;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        CMD_LI    = 2'd0,
        CMD_SW    = 2'd1,
        CMD_LW    = 2'd2,
        CMD_CSRWI = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EMIT1 = 2'd1,
        ST_EMIT2 = 2'd2
    } state_e;

    // Encoded result of one command: up to two words
    typedef struct packed {
        logic [31:0] w0;
        logic [31:0] w1;
        logic        two;
    } enc_seq_t;

    function automatic logic [31:0] enc_i(input logic [11:0] imm12,
                                          input logic [4:0]  rs1,
                                          input logic [2:0]  f3,
                                          input logic [4:0]  rd,
                                          input logic [6:0]  op);
        return {imm12, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm12,
                                          input logic [4:0]  rs2,
                                          input logic [4:0]  rs1,
                                          input logic [2:0]  f3,
                                          input logic [6:0]  op);
        return {imm12[11:5], rs2, rs1, f3, imm12[4:0], op};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm20,
                                          input logic [4:0]  rd,
                                          input logic [6:0]  op);
        return {imm20, rd, op};
    endfunction

endpackage

// File: rtl/imm_ins_encoder.sv
// Turns high-level commands (LI/SW/LW/CSRWI) into RV32I instruction words
// on a valid/ready injection stream; LI may expand to LUI+ADDI.
module imm_ins_encoder
    import imm_ins_encoder_pkg::*;
#(
    parameter logic EN_SHORT_LI = 1'b1,
    parameter logic EN_LO_SKIP  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_rd,
    input  logic [4:0]  cmd_rs1,
    input  logic [4:0]  cmd_rs2,
    input  logic [11:0] cmd_csr,
    input  logic [31:0] cmd_imm,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins,
    output logic        ins_last
);

    state_e      state_q, state_d;
    logic [31:0] ins_q, ins_d;
    logic [31:0] word2_q, word2_d;
    logic        last_q, last_d;
    logic        valid_q, valid_d;
    logic        ready_q, ready_d;

    enc_seq_t    seq;
    logic [11:0] li_lo;
    logic [19:0] li_hi;
    logic        li_short;

    // LUI upper part absorbs the sign of the ADDI low part, wrapping mod 2^20
    assign li_lo    = cmd_imm[11:0];
    assign li_hi    = cmd_imm[31:12] + {19'd0, cmd_imm[11]};
    assign li_short = EN_SHORT_LI && ({{20{li_lo[11]}}, li_lo} == cmd_imm);

    always_comb begin
        seq = '0;
        case (cmd_op_e'(cmd_op))
            CMD_LI: begin
                if (li_short) begin
                    seq.w0 = enc_i(li_lo, REG_X0, F3_ADDI, cmd_rd, OP_IMM);
                end else begin
                    seq.w0  = enc_u(li_hi, cmd_rd, OP_LUI);
                    seq.w1  = enc_i(li_lo, cmd_rd, F3_ADDI, cmd_rd, OP_IMM);
                    seq.two = !(EN_LO_SKIP && (li_lo == 12'd0));
                end
            end
            CMD_SW:
                seq.w0 = enc_s(cmd_imm[11:0], cmd_rs2, cmd_rs1, F3_SW, OP_STORE);
            CMD_LW:
                seq.w0 = enc_i(cmd_imm[11:0], cmd_rs1, F3_LW, cmd_rd, OP_LOAD);
            CMD_CSRWI:
                seq.w0 = enc_i(cmd_csr, cmd_imm[4:0], F3_CSRRWI, REG_X0, OP_SYSTEM);
            default: seq = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ins_d   = ins_q;
        word2_d = word2_q;
        last_d  = last_q;
        valid_d = valid_q;
        ready_d = ready_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_EMIT1;
                    ins_d   = seq.w0;
                    word2_d = seq.w1;
                    last_d  = !seq.two;
                    valid_d = 1'b1;
                    ready_d = 1'b0;
                end
            end
            ST_EMIT1: begin
                if (ins_ready) begin
                    if (!last_q) begin
                        state_d = ST_EMIT2;
                        ins_d   = word2_q;
                        last_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        ins_d   = '0;
                        last_d  = 1'b0;
                        valid_d = 1'b0;
                        ready_d = 1'b1;
                    end
                end
            end
            ST_EMIT2: begin
                if (ins_ready) begin
                    state_d = ST_IDLE;
                    ins_d   = '0;
                    last_d  = 1'b0;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ins_d   = '0;
                last_d  = 1'b0;
                valid_d = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ins_q   <= '0;
            word2_q <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ins_q   <= ins_d;
            word2_q <= word2_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign cmd_ready = ready_q;
    assign ins_valid = valid_q;
    assign ins       = ins_q;
    assign ins_last  = last_q;

endmodule

// File: tb/tb_imm_ins_encoder.sv
// Self-checking bench: directed vectors plus randomized commands against an
// arithmetic reference model of the RV32I encodings.
module tb_imm_ins_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_rd, cmd_rs1, cmd_rs2;
    logic [11:0] cmd_csr;
    logic [31:0] cmd_imm;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] ins;
    logic        ins_last;

    int n_chk  = 0;
    int n_fail = 0;

    imm_ins_encoder dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_csr(cmd_csr), .cmd_imm(cmd_imm),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins), .ins_last(ins_last)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: encodings built with shifts/adds straight from the field layouts
    function automatic void model(input logic [1:0] op, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [11:0] csr, input logic [31:0] imm,
                                  output int n, output logic [31:0] e0,
                                  output logic [31:0] e1);
        logic [31:0] lo, hi;
        int signed   s;
        s  = imm;
        lo = imm & 32'hFFF;
        e1 = 32'h0;
        n  = 1;
        case (op)
            2'd0: begin
                if (s >= -2048 && s <= 2047) begin
                    e0 = (lo << 20) | (32'(rd) << 7) | 32'h13;
                end else begin
                    hi = ((imm + 32'h800) >> 12) & 32'hFFFFF;
                    e0 = (hi << 12) | (32'(rd) << 7) | 32'h37;
                    if (lo != 0) begin
                        n  = 2;
                        e1 = (lo << 20) | (32'(rd) << 15) | (32'(rd) << 7) | 32'h13;
                    end
                end
            end
            2'd1: e0 = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                       | (32'd2 << 12) | ((imm & 32'h1F) << 7) | 32'h23;
            2'd2: e0 = (lo << 20) | (32'(rs1) << 15) | (32'd2 << 12) | (32'(rd) << 7) | 32'h03;
            default: e0 = (32'(csr) << 20) | ((imm & 32'h1F) << 15) | (32'd5 << 12) | 32'h73;
        endcase
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with it idle again
    task automatic run_seq(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [11:0] csr, input logic [31:0] imm,
                           input int n, input logic [31:0] e0, input logic [31:0] e1,
                           input int max_stall);
        logic [31:0] exp;
        int st;
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_csr = csr; cmd_imm = imm;
        cmd_valid = 1'b1;
        ins_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("first_word_valid", 32'(ins_valid), 32'd1);
        for (int k = 0; k < n; k++) begin
            exp = (k == 0) ? e0 : e1;
            st  = (max_stall < 0) ? -max_stall : int'($urandom_range(max_stall, 0));
            for (int s = 0; s < st; s++) begin
                ins_ready = 1'b0;
                chk("stall_valid", 32'(ins_valid), 32'd1);
                chk("stall_ins", ins, exp);
                chk("stall_last", 32'(ins_last), 32'(k == n - 1));
                chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
                @(negedge clk);
            end
            ins_ready = 1'b1;
            chk("word_valid", 32'(ins_valid), 32'd1);
            chk("word_ins", ins, exp);
            chk("word_last", 32'(ins_last), 32'(k == n - 1));
            @(negedge clk);
            ins_ready = 1'b0;
        end
        chk("done_valid", 32'(ins_valid), 32'd0);
        chk("done_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    task automatic run_rand(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [11:0] csr, input logic [31:0] imm);
        int n;
        logic [31:0] e0, e1;
        model(op, rd, rs1, rs2, csr, imm, n, e0, e1);
        run_seq(op, rd, rs1, rs2, csr, imm, n, e0, e1, 2);
    endtask

    initial begin
        logic [31:0] imm;
        rst = 1'b1; cmd_valid = 1'b0; ins_ready = 1'b0;
        cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_csr = '0; cmd_imm = '0;
        #12;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_ins_valid", 32'(ins_valid), 32'd0);
        chk("rst_ins", ins, 32'd0);
        chk("rst_ins_last", 32'(ins_last), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors
        run_seq(2'd0, 5'd5,  5'd0, 5'd0, 12'd0, 32'h12345678, 2, 32'h123452B7, 32'h67828293, 0);
        run_seq(2'd0, 5'd10, 5'd0, 5'd0, 12'd0, 32'h00000800, 2, 32'h00001537, 32'h80050513, 1);
        run_seq(2'd0, 5'd1,  5'd0, 5'd0, 12'd0, 32'hFFFFFFFF, 1, 32'hFFF00093, 32'h0, 0);
        run_seq(2'd0, 5'd2,  5'd0, 5'd0, 12'd0, 32'h00010000, 1, 32'h00010137, 32'h0, 0);
        run_seq(2'd1, 5'd0,  5'd2, 5'd6, 12'd0, 32'hFFFFFFFC, 1, 32'hFE612E23, 32'h0, -3);

        // Back-to-back: second command only accepted after the handshake
        cmd_op = 2'd3; cmd_csr = 12'h300; cmd_imm = 32'd8; cmd_valid = 1'b1; ins_ready = 1'b1;
        @(negedge clk);
        chk("b2b_ins", ins, 32'h30045073);
        chk("b2b_last", 32'(ins_last), 32'd1);
        chk("b2b_busy_ready", 32'(cmd_ready), 32'd0);
        cmd_op = 2'd2; cmd_rd = 5'd7; cmd_rs1 = 5'd3; cmd_imm = 32'h00000010;
        @(negedge clk);
        chk("b2b_gap_valid", 32'(ins_valid), 32'd0);
        chk("b2b_gap_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("b2b_second_ins", ins, 32'h0101A383);
        chk("b2b_second_valid", 32'(ins_valid), 32'd1);
        @(negedge clk);
        ins_ready = 1'b0;
        chk("b2b_done_ready", 32'(cmd_ready), 32'd1);

        // Reset during the second LI word abandons it
        cmd_op = 2'd0; cmd_rd = 5'd5; cmd_imm = 32'h12345678; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; ins_ready = 1'b1;
        chk("rstmid_w0", ins, 32'h123452B7);
        @(negedge clk);
        ins_ready = 1'b0;
        chk("rstmid_w1", ins, 32'h67828293);
        rst = 1'b1;
        #1;
        chk("rstmid_valid", 32'(ins_valid), 32'd0);
        chk("rstmid_ins", ins, 32'd0);
        chk("rstmid_last", 32'(ins_last), 32'd0);
        @(negedge clk);
        rst = 1'b0; ins_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(ins_valid), 32'd0);
            chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        end
        ins_ready = 1'b0;

        // Randomized commands with biased immediates
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(4, 0))
                0: imm = $urandom_range(4095, 0) - 32'd2048;
                1: imm = $urandom & 32'hFFFFF000;
                2: imm = ($urandom & 32'hFFFFF000) | 32'h800;
                default: imm = $urandom;
            endcase
            run_rand(2'($urandom_range(3, 0)), 5'($urandom), 5'($urandom), 5'($urandom),
                     12'($urandom), imm);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
